// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl
// ----------------------------------------------------------------------------
// Frequency-sweep sequencer for the DDS sine path. The block owns the phase
// accumulator. It steps the frequency tuning word (FTW) from start_ftw up to
// stop_ftw and holds each FTW for a programmed dwell. It drives the sine ROM
// address from the top ADDR_W bits of the accumulator.
//
// Optional feature (macro DDS_SWEEP_TRIANGLE_EN):
//   When the macro is undefined, the block runs a single up-sweep and ends in
//   FINISH. When it is defined, the sweep bounces between start_ftw and
//   stop_ftw until abort or reset. done pulses at every return to start_ftw.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   cfg_we     config write strobe (honoured only while idle)
//   cfg_sel    0=start_ftw, 1=stop_ftw, 2=step, 3=dwell (low DWELL_W bits)
//   cfg_data   config write data
//   start      single-cycle sweep launch
//   abort      single-cycle sweep cancel (wins over start)
//   busy       sweep in progress
//   done       one-cycle completion pulse (never on abort or reset)
//   ftw        FTW currently applied
//   addr_out   ROM address, acc[ACC_W-1 -: ADDR_W]
//   addr_vld   addr_out is a live sample address
//   sample_vld addr_vld delayed one cycle, qualifies the registered ROM q
// ----------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int ACC_W   = 32,
    parameter int ADDR_W  = 9,
    parameter int DWELL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [ACC_W-1:0]  cfg_data,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  ftw,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_vld,
    output logic              sample_vld
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ACC_W-1:0]   start_ftw;
    logic [ACC_W-1:0]   stop_ftw;
    logic [ACC_W-1:0]   step;
    logic [DWELL_W-1:0] dwell;

    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [ACC_W-1:0]   ftw_nxt;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nxt;

    logic [ACC_W-1:0]   step_eff;
    logic [DWELL_W-1:0] dwell_reload;
    logic [ACC_W:0]     up_sum;
    logic [ACC_W-1:0]   up_ftw;

`ifdef DDS_SWEEP_TRIANGLE_EN
    logic               dir_down, dir_down_nxt;
    logic               done_pulse, done_pulse_nxt;
    logic [ACC_W:0]     down_diff;
    logic [ACC_W-1:0]   down_ftw;
`endif

    // A step of zero would freeze the sweep, so it is treated as one LSB.
    // A dwell of zero is treated as one cycle per FTW.
    assign step_eff     = (step == '0) ? ACC_W'(1) : step;
    assign dwell_reload = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    // The up-step uses one extra bit so that a wrap past 2^ACC_W clamps to stop_ftw.
    assign up_sum = {1'b0, ftw} + {1'b0, step_eff};
    assign up_ftw = (up_sum >= {1'b0, stop_ftw}) ? stop_ftw : up_sum[ACC_W-1:0];

`ifdef DDS_SWEEP_TRIANGLE_EN
    // The down-step uses one extra bit. A borrow, or a result below start_ftw,
    // clamps to start_ftw.
    assign down_diff = {1'b0, ftw} - {1'b0, step_eff};
    assign down_ftw  = (down_diff[ACC_W] || (down_diff[ACC_W-1:0] < start_ftw))
                       ? start_ftw : down_diff[ACC_W-1:0];
`endif

    // Config registers accept writes only in IDLE. If start and cfg_we share a
    // cycle, the launch still sees the old values, because both update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_ftw <= '0;
            stop_ftw  <= '0;
            step      <= '0;
            dwell     <= '0;
        end else if (cfg_we && (state == IDLE)) begin
            unique case (cfg_sel)
                2'd0: start_ftw <= cfg_data;
                2'd1: stop_ftw  <= cfg_data;
                2'd2: step      <= cfg_data;
                2'd3: dwell     <= cfg_data[DWELL_W-1:0];
                default: ;
            endcase
        end
    end

    // Next-state logic for the sweep state machine, accumulator, FTW and dwell counter.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        ftw_nxt       = ftw;
        dwell_cnt_nxt = dwell_cnt;
`ifdef DDS_SWEEP_TRIANGLE_EN
        dir_down_nxt   = dir_down;
        done_pulse_nxt = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt     = SWEEP;
                    ftw_nxt       = start_ftw;
                    acc_nxt       = '0;
                    dwell_cnt_nxt = dwell_reload;
`ifdef DDS_SWEEP_TRIANGLE_EN
                    dir_down_nxt  = 1'b0;
`endif
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    acc_nxt       = acc + ftw;
                    dwell_cnt_nxt = dwell_cnt - DWELL_W'(1);
                    if (dwell_cnt == '0) begin
                        dwell_cnt_nxt = dwell_reload;
`ifdef DDS_SWEEP_TRIANGLE_EN
                        if (start_ftw >= stop_ftw) begin
                            // An empty range holds start_ftw and reports done after every dwell.
                            done_pulse_nxt = 1'b1;
                        end else if (!dir_down) begin
                            if (ftw < stop_ftw) begin
                                ftw_nxt = up_ftw;
                            end else begin
                                ftw_nxt      = down_ftw;
                                dir_down_nxt = 1'b1;
                            end
                        end else begin
                            if (ftw > start_ftw) begin
                                ftw_nxt = down_ftw;
                            end else begin
                                // Back at start_ftw: one full triangle is complete.
                                ftw_nxt        = up_ftw;
                                dir_down_nxt   = 1'b0;
                                done_pulse_nxt = 1'b1;
                            end
                        end
`else
                        if (ftw < stop_ftw) begin
                            ftw_nxt = up_ftw;
                        end else begin
                            state_nxt = FINISH;
                        end
`endif
                    end
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers. sample_vld is a plain one-cycle delay of
    // addr_vld, so the last ROM read issued before an abort is still flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            ftw        <= '0;
            dwell_cnt  <= '0;
            sample_vld <= 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
            dir_down   <= 1'b0;
            done_pulse <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            ftw        <= ftw_nxt;
            dwell_cnt  <= dwell_cnt_nxt;
            sample_vld <= addr_vld;
`ifdef DDS_SWEEP_TRIANGLE_EN
            dir_down   <= dir_down_nxt;
            done_pulse <= done_pulse_nxt;
`endif
        end
    end

    assign busy     = (state == SWEEP);
    assign addr_vld = (state == SWEEP);
    assign addr_out = acc[ACC_W-1 -: ADDR_W];

`ifdef DDS_SWEEP_TRIANGLE_EN
    assign done = done_pulse;
`else
    assign done = (state == FINISH);
`endif

endmodule
